// File: rtl/switch_port.sv
// Purpose : switch-side endpoint of the device port; ingress FIFO to fabric, 2-entry egress buffer to device.
// Latency : validtx -> acktx 1 cycle (when room) -> ing_valid 1 cycle later; egr push -> validrx next cycle.
// Backpr. : acktx withheld while the ingress FIFO would be full; egr_ready low when egress holds 2 words.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   adr_i, dat_i, validtx, acktx  device -> switch request/accept handshake
//   validrx, ackrx, dat_o         switch -> device streaming handshake
//   ing_valid, ing_adr, ing_dat,  ingress FIFO head offered to the fabric,
//   ing_pop                       popped by the fabric
//   egr_valid, egr_dat, egr_ready fabric -> egress buffer push
//   drop_cnt                      saturating count of illegal-address transfers

// Generic synchronous FIFO: write-first storage, wrapping pointers, count.
// Caller guarantees push only when not full and pop only when not empty.
module switch_port_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           dat_i,
  output logic [W-1:0]           dat_o,
  output logic [$clog2(DEPTH):0] cnt_o,
  output logic [$clog2(DEPTH):0] cnt_nxt_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; clearing the pointers and count discards contents.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= dat_i;
  end

  assign dat_o     = mem_q[rd_q];
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
endmodule

module switch_port #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [2:0]    adr_i,
  input  logic [DW-1:0] dat_i,
  input  logic          validtx,
  output logic          acktx,
  output logic          validrx,
  input  logic          ackrx,
  output logic [DW-1:0] dat_o,
  output logic          ing_valid,
  output logic [2:0]    ing_adr,
  output logic [DW-1:0] ing_dat,
  input  logic          ing_pop,
  input  logic          egr_valid,
  input  logic [DW-1:0] egr_dat,
  output logic          egr_ready,
  output logic [CW-1:0] drop_cnt
);
  localparam int AW_I = $clog2(DEPTH);
  localparam logic [AW_I:0] ING_FULL = (AW_I+1)'(DEPTH);

  logic          acktx_q, acktx_d;
  logic          validrx_q, validrx_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          adr_legal;
  logic          xfer;
  logic          ing_push, ing_pop_ok;
  logic [AW_I:0] ing_cnt, ing_cnt_nxt;
  logic [DW+2:0] ing_head;

  logic          egr_push, egr_pop;
  logic [1:0]    egr_cnt, egr_cnt_nxt;

  // ---------------- ingress ----------------
  // A transfer completes on a cycle where acktx is high and the device is
  // still requesting; acktx without validtx is ignored.
  assign adr_legal  = (adr_i[1:0] != 2'b11);
  assign xfer       = acktx_q & validtx;
  assign ing_push   = xfer & adr_legal;
  assign ing_pop_ok = ing_pop & ing_valid;

  switch_port_fifo #(.W(DW+3), .DEPTH(DEPTH)) u_ing (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (ing_push),
    .pop_i     (ing_pop_ok),
    .dat_i     ({adr_i, dat_i}),
    .dat_o     (ing_head),
    .cnt_o     (ing_cnt),
    .cnt_nxt_o (ing_cnt_nxt)
  );

  // Grant only if the entry accepted next cycle will fit given this cycle's
  // push/pop; never grant on two consecutive cycles.
  always_comb begin
    acktx_d = validtx & ~acktx_q & (ing_cnt_nxt < ING_FULL);
    drop_d  = drop_q;
    if (xfer && !adr_legal && (drop_q != '1)) drop_d = drop_q + CW'(1);
  end

  assign ing_valid = (ing_cnt != '0);
  assign ing_adr   = ing_head[DW+2:DW];
  assign ing_dat   = ing_head[DW-1:0];

  // ---------------- egress ----------------
  assign egr_ready = (egr_cnt != 2'd2);
  assign egr_push  = egr_valid & egr_ready;
  assign egr_pop   = validrx_q & ackrx;

  switch_port_fifo #(.W(DW), .DEPTH(2)) u_egr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (egr_push),
    .pop_i     (egr_pop),
    .dat_i     (egr_dat),
    .dat_o     (dat_o),
    .cnt_o     (egr_cnt),
    .cnt_nxt_o (egr_cnt_nxt)
  );

  // Registered from the next count so validrx tracks (egr_cnt != 0) exactly.
  assign validrx_d = (egr_cnt_nxt != 2'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acktx_q   <= 1'b0;
      validrx_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      acktx_q   <= acktx_d;
      validrx_q <= validrx_d;
      drop_q    <= drop_d;
    end
  end

  assign acktx    = acktx_q;
  assign validrx  = validrx_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_switch_port.sv
module tb_switch_port;
  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int MAXD  = 255;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [2:0]    adr_i = '0;
  logic [DW-1:0] dat_i = '0;
  logic          validtx = 1'b0;
  logic          acktx;
  logic          validrx;
  logic          ackrx = 1'b0;
  logic [DW-1:0] dat_o;
  logic          ing_valid;
  logic [2:0]    ing_adr;
  logic [DW-1:0] ing_dat;
  logic          ing_pop = 1'b0;
  logic          egr_valid = 1'b0;
  logic [DW-1:0] egr_dat = '0;
  logic          egr_ready;
  logic [CW-1:0] drop_cnt;

  switch_port #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i),
    .validtx(validtx), .acktx(acktx), .validrx(validrx), .ackrx(ackrx),
    .dat_o(dat_o), .ing_valid(ing_valid), .ing_adr(ing_adr), .ing_dat(ing_dat),
    .ing_pop(ing_pop), .egr_valid(egr_valid), .egr_dat(egr_dat),
    .egr_ready(egr_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: queues of entries plus the accept/drop rules.
  logic [DW+2:0] ingq[$];
  logic [DW-1:0] egq[$];
  bit            m_ack  = 1'b0;
  int            m_drop = 0;
  int            cyc    = 0;
  int            n_chk  = 0;
  int            n_err  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    bit push, pop, drop, epush, epop, nack;
    int nxt;
    if (rst_i) begin
      ingq.delete();
      egq.delete();
      m_ack  = 1'b0;
      m_drop = 0;
    end else begin
      push  = m_ack && validtx && (adr_i[1:0] != 2'b11);
      drop  = m_ack && validtx && (adr_i[1:0] == 2'b11);
      pop   = ing_pop && (ingq.size() != 0);
      nxt   = ingq.size() + int'(push) - int'(pop);
      nack  = validtx && !m_ack && (nxt < DEPTH);
      if (pop)  void'(ingq.pop_front());
      if (push) ingq.push_back({adr_i, dat_i});
      if (drop && m_drop < MAXD) m_drop++;
      epush = egr_valid && (egq.size() < 2);
      epop  = ackrx && (egq.size() != 0);
      if (epop)  void'(egq.pop_front());
      if (epush) egq.push_back(egr_dat);
      m_ack = nack;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    chk("acktx", 32'(acktx), 32'(m_ack));
    chk("ing_valid", 32'(ing_valid), 32'(ingq.size() != 0));
    if (ingq.size() != 0) begin
      chk("ing_adr", 32'(ing_adr), 32'(ingq[0][DW+2:DW]));
      chk("ing_dat", 32'(ing_dat), 32'(ingq[0][DW-1:0]));
    end
    chk("validrx", 32'(validrx), 32'(egq.size() != 0));
    if (egq.size() != 0) chk("dat_o", 32'(dat_o), 32'(egq[0]));
    chk("egr_ready", 32'(egr_ready), 32'(egq.size() < 2));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Device request held until its ack cycle has completed.
  task automatic dev_send(input logic [2:0] a, input logic [DW-1:0] d);
    bit done = 1'b0;
    validtx = 1'b1;
    adr_i   = a;
    dat_i   = d;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (m_ack) begin
        tick();
        done = 1'b1;
      end
    end
    validtx = 1'b0;
    chk("send_done", 32'(done), 32'd1);
  endtask

  initial begin
    int  pulses, last;
    bit  acked;

    // Reset values
    tick();
    tick();
    chk("rst_acktx", 32'(acktx), 32'd0);
    chk("rst_ing_valid", 32'(ing_valid), 32'd0);
    chk("rst_validrx", 32'(validrx), 32'd0);
    chk("rst_egr_ready", 32'(egr_ready), 32'd1);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Single transfer latency
    rst_i = 1'b0; validtx = 1'b1; adr_i = 3'd2; dat_i = 4'd5;
    tick();
    chk("t1_ack_c1", 32'(acktx), 32'd1);
    tick();
    validtx = 1'b0;
    chk("t1_ack_c2", 32'(acktx), 32'd0);
    chk("t1_ing_valid", 32'(ing_valid), 32'd1);
    chk("t1_ing_adr", 32'(ing_adr), 32'd2);
    chk("t1_ing_dat", 32'(ing_dat), 32'd5);

    // Fill to DEPTH with validtx held; then one pop frees one slot
    do_reset();
    validtx = 1'b1; adr_i = 3'd1; dat_i = '0;
    pulses = 0; last = -10;
    for (int i = 0; i < 14; i++) begin
      acked = m_ack;
      tick();
      if (acked) dat_i = dat_i + 1'b1;
      if (acktx) begin
        pulses++;
        if (pulses > 1) chk("ack_gap", 32'(cyc - last >= 2), 32'd1);
        last = cyc;
      end
    end
    chk("fill_pulses", 32'(pulses), 32'd4);
    pulses = 0;
    ing_pop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      acked = m_ack;
      tick();
      ing_pop = 1'b0;
      if (acked) dat_i = dat_i + 1'b1;
      if (acktx) pulses++;
    end
    chk("refill_pulses", 32'(pulses), 32'd1);
    validtx = 1'b0;
    ing_pop = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ing_pop = 1'b0;
    chk("drained", 32'(ing_valid), 32'd0);

    // Push and pop together at 3 entries, across pointer wrap
    dev_send(3'd0, 4'd1);
    dev_send(3'd1, 4'd2);
    dev_send(3'd2, 4'd3);
    validtx = 1'b1; adr_i = 3'd4; dat_i = 4'd4;
    for (int i = 0; i < 10 && !m_ack; i++) tick();
    chk("t5_ack", 32'(m_ack), 32'd1);
    ing_pop = 1'b1;
    tick();
    ing_pop = 1'b0; validtx = 1'b0;
    chk("t5_cnt", 32'(ingq.size()), 32'd3);
    chk("t5_head", 32'(ing_adr), 32'd1);
    ing_pop = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ing_pop = 1'b0;
    chk("t5_empty", 32'(ing_valid), 32'd0);

    // Illegal addresses are acked and counted, not pushed
    do_reset();
    dev_send(3'd3, 4'd1);
    dev_send(3'd7, 4'd2);
    chk("t3_no_push", 32'(ing_valid), 32'd0);
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    dev_send(3'd4, 4'd9);
    chk("t3_push", 32'(ing_valid), 32'd1);
    chk("t3_adr", 32'(ing_adr), 32'd4);

    // Egress: two words, a third ignored while full, then drained
    egr_valid = 1'b1; egr_dat = 4'hA; tick();
    egr_dat = 4'hB; tick();
    egr_dat = 4'hC; tick();
    egr_valid = 1'b0;
    chk("t4_ready", 32'(egr_ready), 32'd0);
    chk("t4_validrx", 32'(validrx), 32'd1);
    chk("t4_first", 32'(dat_o), 32'hA);
    ackrx = 1'b1; tick();
    chk("t4_second", 32'(dat_o), 32'hB);
    tick();
    ackrx = 1'b0;
    chk("t4_empty", 32'(validrx), 32'd0);
    chk("t4_ready2", 32'(egr_ready), 32'd1);

    // Reset mid-traffic; outstanding validtx re-acked afterwards
    do_reset();
    dev_send(3'd0, 4'd3);
    dev_send(3'd5, 4'd6);
    egr_valid = 1'b1; egr_dat = 4'h7; tick(); egr_valid = 1'b0;
    validtx = 1'b1; adr_i = 3'd6; dat_i = 4'd2;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("t6_acktx", 32'(acktx), 32'd0);
    chk("t6_ing_valid", 32'(ing_valid), 32'd0);
    chk("t6_validrx", 32'(validrx), 32'd0);
    chk("t6_egr_ready", 32'(egr_ready), 32'd1);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    tick();
    chk("t6_reack", 32'(acktx), 32'd1);
    tick();
    validtx = 1'b0;

    // Drop counter saturation
    do_reset();
    validtx = 1'b1; adr_i = 3'd3;
    for (int i = 0; i < 560; i++) tick();
    validtx = 1'b0;
    tick();
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      acked = m_ack;
      if (!validtx) begin
        if ($urandom_range(0, 2) == 0) begin
          validtx = 1'b1;
          adr_i   = 3'($urandom);
          dat_i   = DW'($urandom);
        end
      end else if (acked) begin
        validtx = ($urandom_range(0, 3) == 0);
        adr_i   = 3'($urandom);
        dat_i   = DW'($urandom);
      end else if ($urandom_range(0, 39) == 0) begin
        validtx = 1'b0;
      end
      ing_pop   = ($urandom_range(0, 2) == 0);
      egr_valid = ($urandom_range(0, 1) == 0);
      egr_dat   = DW'($urandom);
      ackrx     = ($urandom_range(0, 2) != 0);
      rst_i     = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
